// File: rtl/m2_pkg.sv
// m2_pkg: shared fetch-state encoding, plane codes and default plane geometry for the milestone-2 S' fetch path
package m2_pkg;
   typedef enum logic [2:0] {S_IDLE, S_INIT, S_ISSUE, S_DRAIN, S_DONE} fetch_state_t;
   localparam logic [1:0] PLANE_Y   = 2'd0;
   localparam logic [1:0] PLANE_U   = 2'd1;
   localparam logic [1:0] PLANE_V   = 2'd2;
   localparam logic [1:0] PLANE_BAD = 2'd3;
   localparam int DEF_Y_OFFSET = 76800;
   localparam int DEF_U_OFFSET = 38400;
   localparam int DEF_V_OFFSET = 57600;
   localparam int DEF_Y_WIDTH  = 320;
   localparam int DEF_UV_WIDTH = 160;
   localparam int DEF_HEIGHT   = 240;
   function automatic int plane_pick(input logic [1:0] p, input int y, input int u, input int v);
      return (p == PLANE_Y) ? y : (p == PLANE_U) ? u : v;
   endfunction
endpackage

// File: rtl/sprime_block_fetch_if.sv
// sprime_block_fetch_if: request, SRAM read and dual-port RAM write signals of the S' block fetcher
//   master: requester/SRAM side (drives start, plane, block_row, block_col, SRAM_read_data)
//   slave : fetcher side (drives SRAM_address, SRAM_we_n, dp_*, busy, done, err)
interface sprime_block_fetch_if;
   logic        start;
   logic [1:0]  plane;
   logic [4:0]  block_row;
   logic [5:0]  block_col;
   logic [15:0] SRAM_read_data;
   logic [17:0] SRAM_address;
   logic        SRAM_we_n;
   logic [6:0]  dp_address;
   logic [31:0] dp_write_data;
   logic        dp_we;
   logic        busy;
   logic        done;
   logic        err;
   modport master (
      output start, plane, block_row, block_col, SRAM_read_data,
      input  SRAM_address, SRAM_we_n, dp_address, dp_write_data, dp_we, busy, done, err
   );
   modport slave (
      input  start, plane, block_row, block_col, SRAM_read_data,
      output SRAM_address, SRAM_we_n, dp_address, dp_write_data, dp_we, busy, done, err
   );
endinterface

// File: rtl/sprime_addr_gen.sv
// sprime_addr_gen: block base computation, raster address stepping and request range check
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_capture         : latch plane/block_row/block_col
//   i_load / i_step   : emit first address / emit next address
//   o_addr            : registered SRAM read address
//   o_last            : the next step emits the final address of the block
//   o_legal           : live request inputs name an in-range block
module sprime_addr_gen
   import m2_pkg::*;
#(
   parameter int BLOCK_DIM = 8,
   parameter int Y_OFFSET  = DEF_Y_OFFSET,
   parameter int U_OFFSET  = DEF_U_OFFSET,
   parameter int V_OFFSET  = DEF_V_OFFSET,
   parameter int Y_WIDTH   = DEF_Y_WIDTH,
   parameter int UV_WIDTH  = DEF_UV_WIDTH,
   parameter int HEIGHT    = DEF_HEIGHT
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_capture,
   input  logic        i_load,
   input  logic        i_step,
   input  logic [1:0]  i_plane,
   input  logic [4:0]  i_block_row,
   input  logic [5:0]  i_block_col,
   output logic [17:0] o_addr,
   output logic        o_last,
   output logic        o_legal
);
   localparam int N    = BLOCK_DIM * BLOCK_DIM;
   localparam int CW   = $clog2(N + 1);
   localparam int COLW = $clog2(BLOCK_DIM);
   logic [1:0]      r_plane;
   logic [4:0]      r_row;
   logic [5:0]      r_bcol;
   logic [17:0]     r_row_base;
   logic [17:0]     r_addr;
   logic [COLW-1:0] r_col;
   logic [CW-1:0]   r_cnt;
   logic [17:0]     w_pitch;
   logic [17:0]     w_base;
   assign w_pitch = 18'(plane_pick(r_plane, Y_WIDTH, UV_WIDTH, UV_WIDTH));
   // (row*pitch + col) * BLOCK_DIM: the pitch product is the single real multiplier
   assign w_base  = 18'(plane_pick(r_plane, Y_OFFSET, U_OFFSET, V_OFFSET))
                  + 18'((18'(r_row) * w_pitch + 18'(r_bcol)) * BLOCK_DIM);
   assign o_legal = (i_plane != PLANE_BAD)
                 && (32'(i_block_col) < 32'(plane_pick(i_plane, Y_WIDTH, UV_WIDTH, UV_WIDTH) / BLOCK_DIM))
                 && (32'(i_block_row) < 32'(HEIGHT / BLOCK_DIM));
   assign o_last  = (r_cnt == CW'(N - 1));
   assign o_addr  = r_addr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_plane    <= '0;
         r_row      <= '0;
         r_bcol     <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
         r_col      <= '0;
         r_cnt      <= '0;
      end else begin
         if (i_capture) begin
            r_plane <= i_plane;
            r_row   <= i_block_row;
            r_bcol  <= i_block_col;
         end
         if (i_load) begin
            r_row_base <= w_base;
            r_addr     <= w_base;
            r_col      <= '0;
            r_cnt      <= CW'(1);
         end else if (i_step) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_col == COLW'(BLOCK_DIM - 1)) begin
               r_row_base <= r_row_base + w_pitch;
               r_addr     <= r_row_base + w_pitch;
               r_col      <= '0;
            end else begin
               r_col  <= r_col + COLW'(1);
               r_addr <= r_addr + 18'd1;
            end
         end
      end
   end
endmodule

// File: rtl/sprime_block_fetch.sv
// sprime_block_fetch: fetch one BLOCK_DIM x BLOCK_DIM block of 16-bit S' samples from SRAM into dual-port RAM as packed pairs
//   CLOCK_50_I : clock, rising edge
//   resetn     : asynchronous active-low reset
//   bus        : request (start/plane/block_row/block_col), SRAM read port, dp write port, busy/done/err status
module sprime_block_fetch
   import m2_pkg::*;
#(
   parameter int BLOCK_DIM    = 8,
   parameter int SRAM_LATENCY = 2,
   parameter int Y_OFFSET     = DEF_Y_OFFSET,
   parameter int U_OFFSET     = DEF_U_OFFSET,
   parameter int V_OFFSET     = DEF_V_OFFSET,
   parameter int Y_WIDTH      = DEF_Y_WIDTH,
   parameter int UV_WIDTH     = DEF_UV_WIDTH,
   parameter int HEIGHT       = DEF_HEIGHT,
   parameter int DP_BASE      = 0
)(
   input logic                 CLOCK_50_I,
   input logic                 resetn,
   sprime_block_fetch_if.slave bus
);
   localparam int N  = BLOCK_DIM * BLOCK_DIM;
   localparam int KW = $clog2(N);
   // every pipe stage except the sampling one; zero here means the pipe drains on this edge
   localparam logic [SRAM_LATENCY-1:0] VLD_REST = {SRAM_LATENCY{1'b1}} >> 1;
   fetch_state_t            r_state;
   logic [SRAM_LATENCY-1:0] r_vld;
   logic [KW-1:0]           r_k;
   logic [15:0]             r_hold;
   logic [6:0]              r_dp_addr;
   logic [31:0]             r_dp_data;
   logic                    r_dp_we;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;
   logic                    r_rej;
   logic                    w_issue;
   logic                    w_last;
   logic                    w_legal;
   logic [17:0]             w_addr;
   assign w_issue = (r_state == S_INIT) || (r_state == S_ISSUE);
   sprime_addr_gen #(
      .BLOCK_DIM(BLOCK_DIM), .Y_OFFSET(Y_OFFSET), .U_OFFSET(U_OFFSET), .V_OFFSET(V_OFFSET),
      .Y_WIDTH(Y_WIDTH), .UV_WIDTH(UV_WIDTH), .HEIGHT(HEIGHT)
   ) u_addr_gen (
      .clk(CLOCK_50_I),
      .rst_n(resetn),
      .i_capture((r_state == S_IDLE) && bus.start),
      .i_load(r_state == S_INIT),
      .i_step(r_state == S_ISSUE),
      .i_plane(bus.plane),
      .i_block_row(bus.block_row),
      .i_block_col(bus.block_col),
      .o_addr(w_addr),
      .o_last(w_last),
      .o_legal(w_legal)
   );
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_vld     <= '0;
         r_k       <= '0;
         r_hold    <= '0;
         r_dp_addr <= '0;
         r_dp_data <= '0;
         r_dp_we   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_rej     <= 1'b0;
      end else begin
         r_vld   <= (r_vld << 1) | SRAM_LATENCY'(w_issue);
         r_dp_we <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         // returning sample k: even ones wait in r_hold, odd ones complete a word
         if (r_vld[SRAM_LATENCY-1]) begin
            r_k <= r_k + KW'(1);
            if (!r_k[0])
               r_hold <= bus.SRAM_read_data;
            else begin
               r_dp_data <= {r_hold, bus.SRAM_read_data};
               r_dp_addr <= 7'(DP_BASE) + 7'(r_k >> 1);
               r_dp_we   <= 1'b1;
            end
         end
         case (r_state)
            S_IDLE:
               if (bus.start) begin
                  r_rej   <= !w_legal;
                  r_busy  <= w_legal;
                  r_state <= w_legal ? S_INIT : S_DONE;
               end
            S_INIT: begin
               r_k     <= '0;
               r_state <= S_ISSUE;
            end
            S_ISSUE:
               if (w_last) r_state <= S_DRAIN;
            S_DRAIN:
               if ((r_vld & VLD_REST) == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end
            S_DONE: begin
               r_done  <= 1'b1;
               r_err   <= r_rej;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign bus.SRAM_address  = w_addr;
   assign bus.SRAM_we_n     = 1'b1;
   assign bus.dp_address    = r_dp_addr;
   assign bus.dp_write_data = r_dp_data;
   assign bus.dp_we         = r_dp_we;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.err           = r_err;
endmodule

// File: tb/tb_sprime_block_fetch.sv
// tb_sprime_block_fetch: default 8x8/latency-2 fetcher and a 4x4/latency-3 build checked against a plane-geometry reference model
module tb_sprime_block_fetch;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       t_sel = 1'b0;
   logic       t_start = 1'b0;
   logic [1:0] t_plane = '0;
   logic [4:0] t_row = '0;
   logic [5:0] t_col = '0;
   int n_chk = 0;
   int n_err = 0;
   int t_first, t_last, t_row2, t_done_e, t_nwr;
   logic [31:0] t_word0;
   always #5 clk = ~clk;
   sprime_block_fetch_if b8();
   sprime_block_fetch_if b4();
   assign b8.start = t_start & ~t_sel;
   assign b4.start = t_start & t_sel;
   assign b8.plane = t_plane;
   assign b4.plane = t_plane;
   assign b8.block_row = t_row;
   assign b4.block_row = t_row;
   assign b8.block_col = t_col;
   assign b4.block_col = t_col;
   // SRAM models: returned word is the low 16 bits of the address, valid LATENCY edges after the address is set
   logic [17:0] q8;
   logic [17:0] q4 [2];
   always @(posedge clk) begin
      q8    <= b8.SRAM_address;
      q4[0] <= b4.SRAM_address;
      q4[1] <= q4[0];
   end
   assign b8.SRAM_read_data = q8[15:0];
   assign b4.SRAM_read_data = q4[1][15:0];
   sprime_block_fetch dut8 (.CLOCK_50_I(clk), .resetn(rst_n), .bus(b8));
   sprime_block_fetch #(.BLOCK_DIM(4), .SRAM_LATENCY(3)) dut4 (.CLOCK_50_I(clk), .resetn(rst_n), .bus(b4));
   logic [17:0] m_addr;
   logic [6:0]  m_dp_a;
   logic [31:0] m_dp_d;
   logic        m_we, m_we_n, m_busy, m_done, m_err;
   assign m_addr = t_sel ? b4.SRAM_address : b8.SRAM_address;
   assign m_dp_a = t_sel ? b4.dp_address : b8.dp_address;
   assign m_dp_d = t_sel ? b4.dp_write_data : b8.dp_write_data;
   assign m_we   = t_sel ? b4.dp_we : b8.dp_we;
   assign m_we_n = t_sel ? b4.SRAM_we_n : b8.SRAM_we_n;
   assign m_busy = t_sel ? b4.busy : b8.busy;
   assign m_done = t_sel ? b4.done : b8.done;
   assign m_err  = t_sel ? b4.err : b8.err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h (sel %0d, t=%0t)", tag, got, exp, t_sel, $time);
      end
   endtask

   task automatic chk_reset();
      chk("rst_addr", 32'(m_addr), 32'd0);
      chk("rst_we_n", 32'(m_we_n), 32'd1);
      chk("rst_dp_a", 32'(m_dp_a), 32'd0);
      chk("rst_dp_d", m_dp_d, 32'd0);
      chk("rst_we", 32'(m_we), 32'd0);
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_done", 32'(m_done), 32'd0);
      chk("rst_err", 32'(m_err), 32'd0);
   endtask

   task automatic run(input logic sel, input logic [1:0] p, input logic [4:0] r, input logic [5:0] c);
      int d, l, n, w, off, last_e, j;
      bit legal, exp_we;
      logic [17:0] exp_a [$];
      logic [17:0] a_before;
      d = sel ? 4 : 8;
      l = sel ? 3 : 2;
      n = d * d;
      w = (p == 2'd0) ? 320 : 160;
      off = (p == 2'd0) ? 76800 : (p == 2'd1) ? 38400 : 57600;
      legal = (p != 2'd3) && (int'(c) < w / d) && (int'(r) < 240 / d);
      for (int i = 0; i < n; i++)
         exp_a.push_back(18'(off + (int'(r) * d + i / d) * w + int'(c) * d + i % d));
      t_first = -1; t_last = -1; t_row2 = -1; t_done_e = -1; t_nwr = 0; t_word0 = '0;
      last_e = legal ? n + l + 1 : 2;
      @(negedge clk);
      t_sel = sel; t_plane = p; t_row = r; t_col = c; t_start = 1'b1;
      #1 a_before = m_addr;
      @(posedge clk);
      @(negedge clk);
      t_start = 1'b0;
      t_plane = 2'($urandom); t_row = 5'($urandom); t_col = 6'($urandom);
      chk("busy_e0", 32'(m_busy), 32'(legal));
      chk("we_e0", 32'(m_we), 32'd0);
      for (int e = 1; e <= last_e; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (m_done && t_done_e < 0) t_done_e = e;
         chk("we_n", 32'(m_we_n), 32'd1);
         if (!legal) begin
            chk("rej_done", 32'(m_done), 32'(e == 1));
            chk("rej_err", 32'(m_err), 32'(e == 1));
            chk("rej_busy", 32'(m_busy), 32'd0);
            chk("rej_addr", 32'(m_addr), 32'(a_before));
            chk("rej_we", 32'(m_we), 32'd0);
         end else begin
            t_start = (e == 10);
            if (e <= n) begin
               chk("addr", 32'(m_addr), 32'(exp_a[e-1]));
               if (e == 1) t_first = int'(m_addr);
               if (e == n) t_last = int'(m_addr);
               if (e == d + 1) t_row2 = int'(m_addr);
            end
            exp_we = (e >= l + 2) && (e <= n + l) && ((e - l) % 2 == 0);
            chk("we", 32'(m_we), 32'(exp_we));
            if (m_we && exp_we) begin
               j = (e - l) / 2 - 1;
               chk("dp_addr", 32'(m_dp_a), 32'(j));
               chk("dp_data", m_dp_d, {exp_a[2*j][15:0], exp_a[2*j+1][15:0]});
               if (j == 0) t_word0 = m_dp_d;
            end
            if (m_we) t_nwr++;
            chk("busy", 32'(m_busy), 32'(e < n + l));
            chk("done", 32'(m_done), 32'(e == n + l + 1));
            chk("err", 32'(m_err), 32'd0);
         end
      end
      t_start = 1'b0;
   endtask

   task automatic rand_req(input logic sel);
      int d, rmax, cmax;
      logic [1:0] p;
      logic [4:0] r;
      logic [5:0] c;
      d = sel ? 4 : 8;
      if ($urandom_range(3, 0) != 0) begin
         p = 2'($urandom_range(2, 0));
         rmax = 240 / d - 1;
         cmax = ((p == 2'd0) ? 320 : 160) / d - 1;
         if (rmax > 31) rmax = 31;
         if (cmax > 63) cmax = 63;
         r = 5'($urandom_range(rmax, 0));
         c = 6'($urandom_range(cmax, 0));
      end else begin
         p = 2'($urandom);
         r = 5'($urandom);
         c = 6'($urandom);
      end
      run(sel, p, r, c);
   endtask

   initial begin
      int seen;
      repeat (3) @(posedge clk);
      @(negedge clk);
      t_sel = 1'b0;
      #1 chk_reset();
      t_sel = 1'b1;
      #1 chk_reset();
      t_sel = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      run(1'b0, 2'd0, 5'd0, 6'd0);
      chk("y00_first", 32'(t_first), 32'd76800);
      chk("y00_row2", 32'(t_row2), 32'd77120);
      chk("y00_word0", t_word0, 32'h2C002C01);
      chk("y00_done_e", 32'(t_done_e), 32'd67);
      run(1'b0, 2'd1, 5'd1, 6'd2);
      chk("u12_first", 32'(t_first), 32'd39696);
      chk("u12_nwr", 32'(t_nwr), 32'd32);
      run(1'b0, 2'd2, 5'd29, 6'd19);
      chk("v2919_first", 32'(t_first), 32'd94872);
      chk("v2919_last", 32'(t_last), 32'd95999);
      run(1'b0, 2'd0, 5'd29, 6'd39);
      chk("y2939_last", 32'(t_last), 32'd153599);
      run(1'b0, 2'd3, 5'd0, 6'd0);
      chk("rej_p3_done_e", 32'(t_done_e), 32'd1);
      run(1'b0, 2'd1, 5'd0, 6'd20);
      chk("rej_c20_done_e", 32'(t_done_e), 32'd1);
      // asynchronous reset in the middle of a fetch
      @(negedge clk);
      t_sel = 1'b0; t_plane = 2'd0; t_row = 5'd3; t_col = 6'd5; t_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      t_start = 1'b0;
      repeat (30) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (m_we || m_busy) seen++;
      end
      chk("rst_quiet", 32'(seen), 32'd0);
      run(1'b0, 2'd0, 5'd3, 6'd5);
      chk("rst_refetch_done_e", 32'(t_done_e), 32'd67);
      for (int i = 0; i < 8; i++) rand_req(1'b0);
      run(1'b1, 2'd0, 5'd2, 6'd3);
      chk("d4_first", 32'(t_first), 32'd79372);
      chk("d4_nwr", 32'(t_nwr), 32'd8);
      chk("d4_done_e", 32'(t_done_e), 32'd20);
      for (int i = 0; i < 5; i++) rand_req(1'b1);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/sprime_block_fetch.md
# sprime_block_fetch

Parametrised SRAM-to-embedded-RAM block fetcher for the milestone-2 IDCT path. On a start pulse it reads one BLOCK_DIM×BLOCK_DIM block of 16-bit S′ samples from a selected plane (Y/U/V) in external SRAM, one address per cycle. It packs sample pairs into 32-bit words and writes them to a dual-port RAM port for the T/S compute stages. It generalises the fixed Y-only 8×8 fetch with per-plane geometry, configurable block size and SRAM latency, and an out-of-range error path.

## Interface
- BLOCK_DIM, 8, block edge in samples; must be even, ≥2
- SRAM_LATENCY, 2, clock edges from SRAM_address register update to SRAM_read_data sampling
- Y_OFFSET / U_OFFSET / V_OFFSET, 76800 / 38400 / 57600, plane base word addresses
- Y_WIDTH / UV_WIDTH, 320 / 160, plane row pitch in words
- HEIGHT, 240, plane height in rows (all planes)
- DP_BASE, 0, first dual-port RAM word address written
- CLOCK_50_I  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- plane  in  2  0=Y, 1=U, 2=V, 3=illegal
- block_row  in  5  block row index
- block_col  in  6  block column index
- SRAM_read_data  in  16  SRAM read bus
- SRAM_address  out  18  registered read address
- SRAM_we_n  out  1  held 1 (read-only block)
- dp_address  out  7  dual-port word address
- dp_write_data  out  32  packed word {even sample, odd sample}
- dp_we  out  1  write enable, one cycle per word
- busy  out  1  high from INIT through DRAIN
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done; 1 = request rejected

## Operation
- FSM: IDLE → INIT → ISSUE → DRAIN → DONE → IDLE.
- IDLE, start=1, legal request → INIT. Illegal request → DONE with err=1; no SRAM or dp activity.
  - Illegal: plane=3, block_col ≥ width/BLOCK_DIM, or block_row ≥ HEIGHT/BLOCK_DIM.
- INIT: row_base = offset(plane) + block_row·BLOCK_DIM·width(plane) + block_col·BLOCK_DIM. This is the only multiply.
- ISSUE: emits N = BLOCK_DIM² addresses, raster order. SRAM_address = row_base + c; after c = BLOCK_DIM−1, row_base += width and c = 0.
- ISSUE ends after the N-th address. DRAIN waits for the remaining returns.
- A SRAM_LATENCY-deep valid shift register tracks the returns.
  - Even sample index k: data latched in a hold register.
  - Odd sample index k: dp_write_data = {hold, SRAM_read_data}, dp_address = DP_BASE + k/2, dp_we = 1 for one cycle.
- DONE: done = 1 for one cycle with err; then IDLE. busy = 0.
- start while busy: ignored, no queueing. Inputs are captured at the start edge, so later changes have no effect.
- Reset (any state): outputs return to reset values, the valid pipe is cleared, no further dp writes.
- Arithmetic: addresses are 18-bit unsigned. The legal-range checks guarantee no wrap. The last legal address per plane is offset + width·HEIGHT − 1.

## Timing
- Reset values: SRAM_address=0, SRAM_we_n=1, dp_address=0, dp_write_data=0, dp_we=0, busy=0, done=0, err=0.
- The start edge is E0.
- Addresses appear after E1..EN, one per cycle, no bubbles.
- Data for address Ek is sampled at Ek+SRAM_LATENCY.
- The last dp_we is set at E(N+SRAM_LATENCY).
- done is set at E(N+SRAM_LATENCY+1): 67 edges for the defaults.
- Rejected request: done=err=1 set at E1; busy stays 0.
- Throughput: one block per N+SRAM_LATENCY+2 cycles, back-to-back starts.

## Structure
- Shared package m2_pkg:
  - fetch state enum
  - plane code constants
  - default plane offsets and widths
- One natural sub-module, sprime_addr_gen:
  - row_base/column counter datapath
  - outputs: address, last_addr, range-check flag
- The top level holds the FSM, valid pipe and packer.

## Test plan
- Y, block (0,0), SRAM model returns addr[15:0]:
  - addresses 76800, 76801, …, 76807, then 77120
  - first dp write: word 0 = {0x2C00, 0x2C01}
  - done at E67, err=0
- U, block (1,2) → first address 39696; 32 dp writes at dp_address 0..31; no write gaps.
- V, block (29,19) → first address 94872, last 95999; Y, block (29,39) → last 153599.
- Illegal plane=3 or block_col=20 with U → done=err=1 at E1; SRAM_address unchanged; dp_we never high.
- resetn low at E30 of a fetch → all outputs at reset values immediately; no dp_we after reset; a new start fetches normally.
- BLOCK_DIM=4, SRAM_LATENCY=3 build, Y block (2,3) → 16 addresses from 79372; 8 dp writes; done at E20.
